// File: rtl/rv32im_csr_counter_bank_pkg.sv
// Shared constants, op encodings and helpers for the machine counter/timer CSR bank.
package rv32im_csr_counter_bank_pkg;

  localparam int unsigned API_XLEN  = 32;
  localparam int unsigned CSR_WIDTH = 12;

  localparam logic [CSR_WIDTH-1:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [CSR_WIDTH-1:0] CSR_MCYCLE_H      = 12'hB80;
  localparam logic [CSR_WIDTH-1:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [CSR_WIDTH-1:0] CSR_MINSTRET_H    = 12'hB82;
  localparam logic [CSR_WIDTH-1:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [CSR_WIDTH-1:0] CSR_CYCLE         = 12'hC00;
  localparam logic [CSR_WIDTH-1:0] CSR_CYCLE_H       = 12'hC80;
  localparam logic [CSR_WIDTH-1:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [CSR_WIDTH-1:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  function automatic logic [API_XLEN-1:0] csr_apply(input csr_op_e op,
                                                    input logic [API_XLEN-1:0] old_val,
                                                    input logic [API_XLEN-1:0] wval);
    logic [API_XLEN-1:0] res;
    unique case (op)
      CsrOpRw: res = wval;
      CsrOpRs: res = old_val | wval;
      CsrOpRc: res = old_val & ~wval;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // Counter slots that physically exist: cycle (0), instret (2), hpm 3..3+num_hpm-1.
  function automatic logic [31:0] impl_mask(input int unsigned num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int unsigned i = 0; i < num_hpm; i++) begin
      m[3+i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rv32im_csr_counter_bank_counter.sv
// Single wide counter split into 32-bit lo and narrower hi halves with write precedence.
module rv32im_csr_counter #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inc_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [31:0]          wdata_i,
  output logic [CNT_WIDTH-1:0] q_o
);

  localparam int unsigned HiWidth = CNT_WIDTH - 32;

  logic [31:0]        lo_q, lo_d;
  logic [HiWidth-1:0] hi_q, hi_d;
  logic [32:0]        lo_sum;
  logic               unused_wdata;

  assign lo_sum       = {1'b0, lo_q} + 33'(inc_i);
  assign unused_wdata = ^wdata_i;

  always_comb begin
    lo_d = lo_sum[31:0];
    hi_d = hi_q + HiWidth'(lo_sum[32]);
    if (wr_lo_i) begin
      // Writing lo swallows this cycle's increment entirely.
      lo_d = wdata_i;
      hi_d = hi_q;
    end else if (wr_hi_i) begin
      // lo still counts, but its carry must not disturb the freshly written hi.
      hi_d = wdata_i[HiWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign q_o = {hi_q, lo_q};

endmodule

// File: rtl/rv32im_csr_counter_bank.sv
// Machine counter/timer CSR bank: mcycle, minstret, mhpmcounters, mcounteren, mcountinhibit.
module rv32im_csr_counter_bank
  import rv32im_csr_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [CSR_WIDTH-1:0] csr_addr_i,
  input  logic [1:0]           csr_op_i,
  input  logic [API_XLEN-1:0]  val_csr_i,
  input  logic                 csr_write_en_i,
  input  logic                 csr_read_en_i,
  input  logic                 instr_retired_i,
  input  logic [NUM_HPM-1:0]   hpm_event_i,
  input  logic [1:0]           priviledge_mode_i,
  output logic [API_XLEN-1:0]  val_csr_o,
  output logic                 csr_hit_o,
  output logic                 csr_illegal_o
);

  localparam logic [31:0] ImplMask = impl_mask(NUM_HPM);

  logic [CNT_WIDTH-1:0] cnt [32];
  logic [31:0]          mcounteren_q, mcounteren_d, mcountinhibit_q, mcountinhibit_d;
  logic [31:0]          event_vec, inc_vec, wr_lo_vec, wr_hi_vec;
  logic [31:0]          rdata, wdata;
  logic [4:0]           idx;
  logic                 is_hi, m_cnt, u_cnt, sel_en, sel_inh, hit, access, is_write;
  logic                 illegal, wr_commit, unused_vec;
  csr_op_e              op;

  assign op       = csr_op_e'(csr_op_i);
  assign idx      = csr_addr_i[4:0];
  assign is_hi    = csr_addr_i[7];
  // Counter windows are x00..x1F (lo) and x80..x9F (hi).
  assign m_cnt    = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[6:5] == 2'b00);
  assign u_cnt    = (csr_addr_i[11:8] == 4'hC) && (csr_addr_i[6:5] == 2'b00);
  assign sel_en   = (csr_addr_i == CSR_MCOUNTEREN);
  assign sel_inh  = (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign hit      = m_cnt | u_cnt | sel_en | sel_inh;
  assign access   = csr_read_en_i | csr_write_en_i;
  assign is_write = csr_write_en_i && (op != CsrOpNone);

  always_comb begin
    illegal = 1'b0;
    if ((m_cnt || sel_en || sel_inh) && (priviledge_mode_i != PRIV_M)) illegal = 1'b1;
    if (u_cnt && is_write) illegal = 1'b1;
    if (u_cnt && (priviledge_mode_i != PRIV_M) && !mcounteren_q[idx]) illegal = 1'b1;
    if ((m_cnt || u_cnt) && !ImplMask[idx]) illegal = 1'b1;
    illegal = illegal && access && hit;
  end

  always_comb begin
    rdata = '0;
    if (sel_en) begin
      rdata = mcounteren_q;
    end else if (sel_inh) begin
      rdata = mcountinhibit_q;
    end else if (is_hi) begin
      rdata = 32'(cnt[idx][CNT_WIDTH-1:32]);
    end else begin
      rdata = cnt[idx][31:0];
    end
  end

  assign wdata     = csr_apply(op, rdata, val_csr_i);
  assign wr_commit = is_write && hit && !illegal;

  assign val_csr_o     = (rst_n_i && csr_read_en_i && hit && !illegal) ? rdata : '0;
  assign csr_hit_o     = rst_n_i && hit;
  assign csr_illegal_o = rst_n_i && illegal;

  always_comb begin
    mcounteren_d    = mcounteren_q;
    mcountinhibit_d = mcountinhibit_q;
    wr_lo_vec       = '0;
    wr_hi_vec       = '0;
    if (wr_commit) begin
      if (sel_en)  mcounteren_d    = wdata & ImplMask;
      if (sel_inh) mcountinhibit_d = wdata & ImplMask;
      if (m_cnt) begin
        if (is_hi) wr_hi_vec[idx] = 1'b1;
        else       wr_lo_vec[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    event_vec    = '0;
    event_vec[0] = 1'b1;
    event_vec[2] = instr_retired_i;
    for (int unsigned i = 0; i < NUM_HPM; i++) begin
      event_vec[3+i] = hpm_event_i[i];
    end
  end

  // Registered inhibit means a new inhibit value only takes effect from the next cycle.
  assign inc_vec    = event_vec & ~mcountinhibit_q & ImplMask;
  assign unused_vec = ^{inc_vec, wr_lo_vec, wr_hi_vec};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mcounteren_q    <= '0;
      mcountinhibit_q <= '0;
    end else begin
      mcounteren_q    <= mcounteren_d;
      mcountinhibit_q <= mcountinhibit_d;
    end
  end

  for (genvar k = 0; k < 32; k++) begin : g_cnt
    if (ImplMask[k]) begin : g_impl
      rv32im_csr_counter #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (inc_vec[k]),
        .wr_lo_i (wr_lo_vec[k]),
        .wr_hi_i (wr_hi_vec[k]),
        .wdata_i (wdata),
        .q_o     (cnt[k])
      );
    end else begin : g_none
      assign cnt[k] = '0;
    end
  end

endmodule

// File: tb/tb_rv32im_csr_counter_bank.sv
// Directed self-checking bench for the counter CSR bank with hand-computed expectations.
module tb_rv32im_csr_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] val_in;
  logic        we, re, instr_ret;
  logic [3:0]  hpm_ev;
  logic [1:0]  priv;
  logic [31:0] val_out;
  logic        hit, ill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32im_csr_counter_bank #(
    .NUM_HPM  (4),
    .CNT_WIDTH(64)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .csr_addr_i       (csr_addr),
    .csr_op_i         (csr_op),
    .val_csr_i        (val_in),
    .csr_write_en_i   (we),
    .csr_read_en_i    (re),
    .instr_retired_i  (instr_ret),
    .hpm_event_i      (hpm_ev),
    .priviledge_mode_i(priv),
    .val_csr_o        (val_out),
    .csr_hit_o        (hit),
    .csr_illegal_o    (ill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Combinational read; takes 1ns and never crosses a clock edge.
  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic i, output logic h);
    csr_addr = a;
    re       = 1'b1;
    #1;
    d  = val_out;
    i  = ill;
    h  = hit;
    re = 1'b0;
  endtask

  // Write committed on the next rising edge; returns the illegal flag seen before the edge.
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v,
                    output logic i);
    csr_addr = a;
    csr_op   = op;
    val_in   = v;
    we       = 1'b1;
    #1;
    i = ill;
    @(posedge clk);
    #1;
    we     = 1'b0;
    csr_op = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        i, h;

    rst_n = 1'b0; csr_addr = 12'hB00; csr_op = 2'b00; val_in = '0;
    we = 1'b0; re = 1'b1; instr_ret = 1'b0; hpm_ev = '0; priv = 2'b11;

    // 1: reset and free-running mcycle
    repeat (2) @(posedge clk);
    #1;
    check("rst_val", val_out, 32'h0);
    check("rst_hit", {31'b0, hit}, 32'h0);
    check("rst_ill", {31'b0, ill}, 32'h0);
    rst_n = 1'b1;
    re    = 1'b0;
    rd(12'hB00, d, i, h); check("t1_mcycle0", d, 32'h0); check("t1_hit", {31'b0, h}, 32'h1);
    rd(12'hB02, d, i, h); check("t1_minstret0", d, 32'h0);
    rd(12'h320, d, i, h); check("t1_inhibit0", d, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    rd(12'hB00, d, i, h); check("t1_mcycle5", d, 32'h5);
    rd(12'hB02, d, i, h); check("t1_minstret_still0", d, 32'h0);

    // 2: carry, wrap and hi-write carry discard
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE, i);
    wr(12'hB80, 2'b01, 32'h0, i);
    repeat (3) @(posedge clk);
    #1;
    rd(12'hB80, d, i, h); check("t2_carry_hi", d, 32'h1);
    rd(12'hB00, d, i, h); check("t2_carry_lo", d, 32'h2);
    wr(12'hB80, 2'b01, 32'hFFFF_FFFF, i);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF, i);
    @(posedge clk);
    #1;
    rd(12'hB00, d, i, h); check("t2_wrap_lo", d, 32'h0);
    rd(12'hB80, d, i, h); check("t2_wrap_hi", d, 32'h0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF, i);
    wr(12'hB80, 2'b01, 32'h5, i);
    rd(12'hB80, d, i, h); check("t2_hiwr_nocarry", d, 32'h5);
    rd(12'hB00, d, i, h); check("t2_hiwr_lo_inc", d, 32'h0);

    // 3: mcountinhibit freezes and resumes mcycle
    wr(12'h320, 2'b10, 32'h0000_0005, i);
    rd(12'h320, d, i, h); check("t3_inhibit_rd", d, 32'h5);
    rd(12'hB00, d, i, h); check("t3_frozen_a", d, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rd(12'hB00, d, i, h); check("t3_frozen_b", d, 32'h1);
    wr(12'h320, 2'b10, 32'h0000_0002, i);
    rd(12'h320, d, i, h); check("t3_bit1_zero", d, 32'h5);
    wr(12'h320, 2'b11, 32'h0000_0001, i);
    repeat (2) @(posedge clk);
    #1;
    rd(12'hB00, d, i, h); check("t3_resumed", d, 32'h3);
    wr(12'h320, 2'b01, 32'hFFFF_FFFF, i);
    rd(12'h320, d, i, h); check("t3_inhibit_mask", d, 32'h0000_007D);
    wr(12'h320, 2'b01, 32'h0, i);

    // 4: minstret write collides with first retire pulse
    instr_ret = 1'b1;
    wr(12'hB02, 2'b01, 32'd10, i);
    instr_ret = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1; instr_ret = 1'b1;
      @(posedge clk); #1; instr_ret = 1'b0;
    end
    rd(12'hB02, d, i, h); check("t4_minstret", d, 32'd12);
    rd(12'hB82, d, i, h); check("t4_minstret_hi", d, 32'h0);

    // 5: user-mode shadows and mcounteren
    priv = 2'b00;
    rd(12'hC00, d, i, h);
    check("t5_u_noen_ill", {31'b0, i}, 32'h1);
    check("t5_u_noen_val", d, 32'h0);
    check("t5_u_noen_hit", {31'b0, h}, 32'h1);
    rd(12'hB00, d, i, h); check("t5_u_mspace_ill", {31'b0, i}, 32'h1);
    priv = 2'b11;
    wr(12'h306, 2'b01, 32'h1, i);
    rd(12'h306, d, i, h); check("t5_mcounteren", d, 32'h1);
    wr(12'hB00, 2'b01, 32'h100, i);
    priv = 2'b00;
    rd(12'hC00, d, i, h);
    check("t5_u_en_ill", {31'b0, i}, 32'h0);
    check("t5_u_en_val", d, 32'h100);
    rd(12'hC02, d, i, h); check("t5_u_instret_ill", {31'b0, i}, 32'h1);
    wr(12'hC00, 2'b01, 32'h0, i);
    check("t5_u_wr_ill", {31'b0, i}, 32'h1);
    rd(12'hC00, d, i, h); check("t5_u_wr_nochange", d, 32'h101);
    priv = 2'b11;

    // 6: hpm event counting and unimplemented indices
    for (int p = 0; p < 7; p++) begin
      hpm_ev = 4'b0001;
      @(posedge clk); #1;
      hpm_ev = 4'b0000;
      @(posedge clk); #1;
    end
    rd(12'hB03, d, i, h); check("t6_hpm3", d, 32'd7);
    rd(12'hB04, d, i, h); check("t6_hpm4", d, 32'd0);
    rd(12'hB07, d, i, h);
    check("t6_b07_ill", {31'b0, i}, 32'h1);
    check("t6_b07_val", d, 32'h0);
    check("t6_b07_hit", {31'b0, h}, 32'h1);
    rd(12'hB01, d, i, h); check("t6_time_ill", {31'b0, i}, 32'h1);
    rd(12'h300, d, i, h); check("t6_nohit_300", {31'b0, h}, 32'h0);
    rd(12'hB20, d, i, h); check("t6_nohit_b20", {31'b0, h}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
